// File: rtl/pu_riscv_memory_stage_if.sv
// Data-memory response channel that the memory stage consumes.
// The memory side drives it; the stage only listens.
interface pu_riscv_memory_stage_if #(
   parameter int XLEN = 64
) ();
   logic            dmem_ack;
   logic [XLEN-1:0] dmem_q;
   logic            dmem_misaligned;
   logic            dmem_page_fault;

   // Every response is a one-cycle pulse with no back-pressure, so the stage must take it in the cycle it appears.
   modport master (output dmem_ack, dmem_q, dmem_misaligned, dmem_page_fault);
   modport slave  (input  dmem_ack, dmem_q, dmem_misaligned, dmem_page_fault);
endinterface

// File: rtl/pu_riscv_memory_stage.sv
// Memory stage: registers EX results into MEM/WB, holds the pipeline while a load is in flight,
// and aligns/extends load data or turns dmem faults into exception bits.
module pu_riscv_memory_stage #(
   parameter int              XLEN           = 64,
   parameter int              ILEN           = 32,
   parameter int              EXCEPTION_SIZE = 16,
   parameter logic [XLEN-1:0] PC_INIT        = 'h200
) (
   input  logic                      clk,
   input  logic                      rst,
   pu_riscv_memory_stage_if.slave    i_dmem,
   input  logic                      i_wb_stall,
   output logic                      o_mem_stall,
   input  logic                      i_bu_flush,
   input  logic                      i_st_flush,
   input  logic [XLEN-1:0]           i_ex_pc,
   input  logic [ILEN-1:0]           i_ex_instr,
   input  logic                      i_ex_bubble,
   input  logic [EXCEPTION_SIZE-1:0] i_ex_exception,
   input  logic [XLEN-1:0]           i_ex_r,
   input  logic                      i_ex_load,
   input  logic [2:0]                i_ex_load_size,
   output logic [XLEN-1:0]           o_mem_pc,
   output logic [ILEN-1:0]           o_mem_instr,
   output logic                      o_mem_bubble,
   output logic [EXCEPTION_SIZE-1:0] o_mem_exception,
   output logic [XLEN-1:0]           o_mem_r,
   output logic [1:0]                o_state
);

   localparam int                      OFF_W   = (XLEN == 64) ? 3 : 2;
   localparam logic [ILEN-1:0]         NOP     = ILEN'(32'h0000_0013);
   localparam logic [EXCEPTION_SIZE-1:0] EXC_MA = EXCEPTION_SIZE'(1) << 4;
   localparam logic [EXCEPTION_SIZE-1:0] EXC_PF = EXCEPTION_SIZE'(1) << 13;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t                    r_state;
   logic [XLEN-1:0]           r_pc;
   logic [ILEN-1:0]           r_instr;
   logic                      r_bubble;
   logic [EXCEPTION_SIZE-1:0] r_exception;
   logic [XLEN-1:0]           r_r;
   logic [2:0]                r_size;
   logic [OFF_W-1:0]          r_off;

   logic                      w_flush;
   logic                      w_resp;
   logic                      w_load_start;
   logic [XLEN-1:0]           w_load_data;

   // Shift the addressed bytes down to bit 0, then extend according to funct3.
   function automatic logic [XLEN-1:0] f_extend(input logic [XLEN-1:0]  q,
                                                input logic [OFF_W-1:0] off,
                                                input logic [2:0]       size);
      logic [XLEN-1:0] s;
      s = q >> {off, 3'b000};
      case (size)
         3'd0:    f_extend = XLEN'($signed(s[7:0]));
         3'd1:    f_extend = XLEN'($signed(s[15:0]));
         3'd3:    f_extend = (XLEN == 64) ? s : XLEN'($signed(s[31:0]));
         3'd4:    f_extend = XLEN'(s[7:0]);
         3'd5:    f_extend = XLEN'(s[15:0]);
         3'd6:    f_extend = (XLEN == 64) ? XLEN'(s[31:0]) : XLEN'($signed(s[31:0]));
         default: f_extend = XLEN'($signed(s[31:0]));
      endcase
   endfunction

   assign w_flush      = i_bu_flush | i_st_flush;
   assign w_resp       = i_dmem.dmem_ack | i_dmem.dmem_misaligned | i_dmem.dmem_page_fault;
   assign w_load_start = i_ex_load & ~i_ex_bubble & (i_ex_exception == '0);
   assign w_load_data  = f_extend(i_dmem.dmem_q, r_off, r_size);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_pc        <= PC_INIT;
         r_instr     <= NOP;
         r_bubble    <= 1'b1;
         r_exception <= '0;
         r_r         <= '0;
         r_size      <= '0;
         r_off       <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (!i_wb_stall) begin
                  r_pc    <= i_ex_pc;
                  r_instr <= i_ex_instr;
                  if (w_flush) begin
                     r_bubble    <= 1'b1;
                     r_exception <= '0;
                     r_r         <= i_ex_r;
                  end else begin
                     r_exception <= i_ex_exception;
                     if (w_load_start) begin
                        r_size   <= i_ex_load_size;
                        r_off    <= i_ex_r[OFF_W-1:0];
                        r_bubble <= 1'b1;
                        r_state  <= WAIT;
                     end else begin
                        r_r      <= i_ex_r;
                        r_bubble <= i_ex_bubble;
                     end
                  end
               end
            end
            WAIT: begin
               // A flush kills the load even when its response lands in the same cycle.
               if (w_flush) begin
                  r_bubble <= 1'b1;
                  r_state  <= w_resp ? IDLE : DRAIN;
               end else if (w_resp) begin
                  r_state  <= IDLE;
                  r_bubble <= 1'b0;
                  if (i_dmem.dmem_misaligned) begin
                     r_exception <= r_exception | EXC_MA;
                     r_r         <= '0;
                  end else if (i_dmem.dmem_page_fault) begin
                     r_exception <= r_exception | EXC_PF;
                     r_r         <= '0;
                  end else begin
                     r_r <= w_load_data;
                  end
               end
            end
            DRAIN: begin
               if (w_resp) r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign o_mem_stall     = (r_state != IDLE);
   assign o_mem_pc        = r_pc;
   assign o_mem_instr     = r_instr;
   assign o_mem_bubble    = r_bubble;
   assign o_mem_exception = r_exception;
   assign o_mem_r         = r_r;
   assign o_state         = r_state;

endmodule

// File: tb/tb_pu_riscv_memory_stage.sv
// Randomized scoreboard bench for the memory stage: the driver pushes expected MEM results,
// and a negedge monitor compares whatever the stage presents to writeback.
module tb_pu_riscv_memory_stage;

   localparam int          XLEN    = 64;
   localparam int          ILEN    = 32;
   localparam int          ESZ     = 16;
   localparam int          W       = XLEN + ILEN + ESZ + XLEN;
   localparam logic [63:0] PC_INIT = 64'h200;
   localparam logic [1:0]  ST_IDLE  = 2'd0;
   localparam logic [1:0]  ST_DRAIN = 2'd2;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            wb_stall = 1'b0;
   logic            bu_flush = 1'b0;
   logic            st_flush = 1'b0;
   logic [63:0]     ex_pc = '0;
   logic [31:0]     ex_instr = '0;
   logic            ex_bubble = 1'b1;
   logic [15:0]     ex_exception = '0;
   logic [63:0]     ex_r = '0;
   logic            ex_load = 1'b0;
   logic [2:0]      ex_load_size = '0;
   logic            mem_stall;
   logic [63:0]     mem_pc;
   logic [31:0]     mem_instr;
   logic            mem_bubble;
   logic [15:0]     mem_exception;
   logic [63:0]     mem_r;
   logic [1:0]      state_dbg;

   pu_riscv_memory_stage_if #(.XLEN(XLEN)) dmem_if ();

   pu_riscv_memory_stage #(
      .XLEN(XLEN), .ILEN(ILEN), .EXCEPTION_SIZE(ESZ), .PC_INIT(PC_INIT)
   ) dut (
      .clk(clk), .rst(rst), .i_dmem(dmem_if.slave),
      .i_wb_stall(wb_stall), .o_mem_stall(mem_stall),
      .i_bu_flush(bu_flush), .i_st_flush(st_flush),
      .i_ex_pc(ex_pc), .i_ex_instr(ex_instr), .i_ex_bubble(ex_bubble),
      .i_ex_exception(ex_exception), .i_ex_r(ex_r), .i_ex_load(ex_load),
      .i_ex_load_size(ex_load_size),
      .o_mem_pc(mem_pc), .o_mem_instr(mem_instr), .o_mem_bubble(mem_bubble),
      .o_mem_exception(mem_exception), .o_mem_r(mem_r), .o_state(state_dbg)
   );

   // Clock / reset
   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_fail = 0;
   logic [W-1:0] exp_q[$];

   initial begin
      dmem_if.dmem_ack        = 1'b0;
      dmem_if.dmem_q          = '0;
      dmem_if.dmem_misaligned = 1'b0;
      dmem_if.dmem_page_fault = 1'b0;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference load model: select bytes with plain arithmetic and wrap negative values modulo 2^64.
   function automatic logic [63:0] ref_load(input logic [63:0] q, input int off, input int size);
      logic [63:0] s, v;
      s = q >> (8 * off);
      case (size)
         0: begin v = s % 64'h100;         if (v >= 64'h80)        v = v - 64'h100; end
         1: begin v = s % 64'h1_0000;      if (v >= 64'h8000)      v = v - 64'h1_0000; end
         3: v = s;
         4: v = s % 64'h100;
         5: v = s % 64'h1_0000;
         6: v = s % 64'h1_0000_0000;
         default: begin v = s % 64'h1_0000_0000; if (v >= 64'h8000_0000) v = v - 64'h1_0000_0000; end
      endcase
      return v;
   endfunction

   task automatic set_resp(input int kind, input logic [63:0] q);
      dmem_if.dmem_q          = q;
      dmem_if.dmem_ack        = (kind == 0);
      dmem_if.dmem_misaligned = (kind == 1) || (kind == 3);
      dmem_if.dmem_page_fault = (kind == 2) || (kind == 3);
   endtask

   task automatic clr_resp();
      dmem_if.dmem_ack        = 1'b0;
      dmem_if.dmem_misaligned = 1'b0;
      dmem_if.dmem_page_fault = 1'b0;
   endtask

   task automatic set_flush(input bit on, input int fsel);
      bu_flush = on && (fsel == 0);
      st_flush = on && (fsel != 0);
   endtask

   // mode: 0 normal response, 1 flush then late response, 2 flush with response
   // resp: 0 ack, 1 misaligned, 2 page fault, 3 misaligned+page fault
   task automatic do_txn(input logic [63:0] pc, input logic [31:0] instr, input logic [15:0] exc,
                         input logic [63:0] r, input bit bub, input bit load, input logic [2:0] size,
                         input bit flush, input int fsel, input int pre_stall, input int mode,
                         input int lat1, input int lat2, input logic [63:0] q, input int resp,
                         input bit wbs_resp);
      bit          is_load;
      int          stall_cnt;
      logic [15:0] e_exc;
      logic [63:0] e_r;
      ex_pc = pc; ex_instr = instr; ex_exception = exc; ex_r = r;
      ex_bubble = bub; ex_load = load; ex_load_size = size;
      for (int k = 0; k < pre_stall; k++) begin
         wb_stall = 1'b1;
         set_flush(0, 0);
         step();
      end
      wb_stall = 1'b0;
      set_flush(flush, fsel);
      is_load = load && !bub && (exc == 16'h0) && !flush;
      if (!flush && !is_load && !bub) exp_q.push_back({pc, instr, exc, r});
      step();
      set_flush(0, 0);
      ex_pc = {$urandom(), $urandom()}; ex_r = {$urandom(), $urandom()};
      ex_instr = $urandom(); ex_bubble = 1'($urandom_range(0, 1)); ex_load = 1'b1;
      if (flush) begin
         chk("flush_bubble", 64'(mem_bubble), 64'd1);
         chk("flush_exc", 64'(mem_exception), 64'd0);
         chk("flush_pc", mem_pc, pc);
         chk("flush_stall", 64'(mem_stall), 64'd0);
      end else if (!is_load) begin
         chk("alu_stall", 64'(mem_stall), 64'd0);
         chk("alu_bubble", 64'(mem_bubble), 64'(bub));
         if (!bub) chk("alu_r", mem_r, r);
      end else begin
         chk("load_wait_bubble", 64'(mem_bubble), 64'd1);
         stall_cnt = 0;
         for (int k = 0; k < lat1; k++) begin
            if (mem_stall) stall_cnt++;
            wb_stall = 1'($urandom_range(0, 1));
            step();
         end
         if (mem_stall) stall_cnt++;
         if (mode == 0) begin
            set_resp(resp, q);
            wb_stall = wbs_resp;
            if (resp == 0) begin e_exc = 16'h0; e_r = ref_load(q, int'(r % 8), int'(size)); end
            else begin e_exc = (resp == 2) ? 16'h2000 : 16'h0010; e_r = 64'h0; end
            exp_q.push_back({pc, instr, e_exc, e_r});
            step();
            clr_resp();
            chk("load_stall_cycles", 64'(stall_cnt), 64'(lat1 + 1));
            chk("load_stall_drop", 64'(mem_stall), 64'd0);
            chk("load_bubble_out", 64'(mem_bubble), 64'd0);
            chk("load_r", mem_r, e_r);
            chk("load_exc", 64'(mem_exception), 64'(e_exc));
         end else if (mode == 1) begin
            set_flush(1, fsel);
            step();
            set_flush(0, 0);
            chk("drain_state", 64'(state_dbg), 64'(ST_DRAIN));
            chk("drain_bubble", 64'(mem_bubble), 64'd1);
            chk("drain_stall", 64'(mem_stall), 64'd1);
            for (int k = 0; k < lat2; k++) step();
            set_resp(resp, q);
            step();
            clr_resp();
            chk("drain_exit_stall", 64'(mem_stall), 64'd0);
            chk("drain_exit_state", 64'(state_dbg), 64'(ST_IDLE));
            chk("drain_discard_bubble", 64'(mem_bubble), 64'd1);
         end else begin
            set_flush(1, fsel);
            set_resp(resp, q);
            step();
            set_flush(0, 0);
            clr_resp();
            chk("flush_resp_stall", 64'(mem_stall), 64'd0);
            chk("flush_resp_bubble", 64'(mem_bubble), 64'd1);
            chk("flush_resp_state", 64'(state_dbg), 64'(ST_IDLE));
         end
      end
   endtask

   // Scoreboard monitor: a non-bubble MEM slot is consumed by WB on any edge without wb_stall.
   initial begin
      logic [W-1:0] cur;
      forever begin
         @(negedge clk);
         if (!rst && !mem_bubble) begin
            cur = {mem_pc, mem_instr, mem_exception, mem_r};
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_output: got %h with no expected entry", cur);
            end else if (cur !== exp_q[0]) begin
               n_fail++;
               $display("FAIL mem_out: got %h expected %h", cur, exp_q[0]);
            end
            if (!wb_stall && exp_q.size() > 0) void'(exp_q.pop_front());
         end
      end
   end

   initial begin
      logic [63:0] r64;
      repeat (3) step();
      rst = 1'b0;
      chk("rst_bubble", 64'(mem_bubble), 64'd1);
      chk("rst_pc", mem_pc, PC_INIT);
      chk("rst_instr", 64'(mem_instr), 64'h13);
      chk("rst_stall", 64'(mem_stall), 64'd0);
      chk("rst_exc", 64'(mem_exception), 64'd0);
      chk("rst_r", mem_r, 64'd0);

      do_txn(64'h1000, 32'h0000_0033, 16'h0, 64'h1234, 0, 0, 3'd0, 0, 0, 0, 0, 0, 0, 64'h0, 0, 0);
      do_txn(64'h1004, 32'h0000_0003, 16'h0, 64'h8000_0003, 0, 1, 3'd0, 0, 0, 0, 0, 2, 0,
             64'h0000_0000_8000_0000, 0, 0);
      do_txn(64'h1008, 32'h0000_5003, 16'h0, 64'h8000_0006, 0, 1, 3'd5, 0, 0, 0, 0, 1, 0,
             64'hBEEF_0000_0000_0000, 0, 0);
      do_txn(64'h100C, 32'h0000_6003, 16'h0, 64'h8000_0004, 0, 1, 3'd6, 0, 0, 0, 0, 0, 0,
             64'h8000_0001_1234_5678, 0, 0);
      do_txn(64'h1010, 32'h0000_2003, 16'h0, 64'h8000_0010, 0, 1, 3'd2, 0, 0, 0, 0, 1, 0,
             64'hDEAD_BEEF_DEAD_BEEF, 2, 0);
      do_txn(64'h1014, 32'h0000_2003, 16'h0, 64'h8000_0011, 0, 1, 3'd2, 0, 0, 0, 0, 0, 0,
             64'hDEAD_BEEF_DEAD_BEEF, 3, 0);
      do_txn(64'h1018, 32'h0000_2003, 16'h0, 64'h8000_0020, 0, 1, 3'd2, 0, 0, 0, 1, 1, 2,
             64'h1111_2222_3333_4444, 0, 0);
      do_txn(64'h101C, 32'h0000_4003, 16'h0, 64'h8000_0030, 0, 1, 3'd4, 0, 0, 0, 0, 1, 0,
             64'h0000_0000_0000_0055, 0, 1);
      do_txn(64'h1020, 32'h0000_0013, 16'h0, 64'h9999, 0, 0, 3'd0, 0, 0, 3, 0, 0, 0, 64'h0, 0, 0);
      do_txn(64'h1024, 32'h0000_0003, 16'h0, 64'h8000_0040, 0, 1, 3'd0, 0, 1, 0, 2, 1, 0,
             64'h0000_0000_0000_00FF, 0, 0);
      do_txn(64'h1028, 32'h0000_0003, 16'h0, 64'h8000_0050, 0, 1, 3'd0, 1, 0, 0, 0, 0, 0,
             64'h0, 0, 0);

      for (int i = 0; i < 300; i++) begin
         int sel;
         int mode;
         int resp;
         logic [15:0] exc;
         sel  = $urandom_range(0, 9);
         mode = (sel < 8) ? 0 : (sel == 8) ? 1 : 2;
         sel  = $urandom_range(0, 9);
         resp = (sel < 7) ? 0 : sel - 6;
         exc  = ($urandom_range(0, 9) == 0) ? (16'h1 << $urandom_range(0, 15)) : 16'h0;
         r64  = {$urandom(), $urandom()};
         do_txn({$urandom(), $urandom()}, $urandom(), exc, r64,
                ($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 6)),
                ($urandom_range(0, 9) == 0), $urandom_range(0, 1),
                ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0,
                mode, $urandom_range(0, 3), $urandom_range(0, 3), {$urandom(), $urandom()},
                resp, 1'($urandom_range(0, 1)));
      end

      wb_stall = 1'b0;
      ex_bubble = 1'b1;
      ex_load = 1'b0;
      repeat (3) step();
      chk("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
